// File: rtl/rle_capture_ctrl.sv
// rle_capture_ctrl: arms rle_enc, gates samples through a capture, then flushes.
// Optional macro RLE_CAPTURE_CTRL_OUTCNT_EN builds the encoder output word counter.
module rle_capture_ctrl #(
    parameter int CW           = 32,
    parameter int FLUSH_CYCLES = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          arm,
    input  logic          abort,
    input  logic          rle_on,
    input  logic [CW-1:0] post_count,
    input  logic          trigger,
    input  logic          smp_valid,
    output logic          enc_valid,
    output logic          enc_enable,
    output logic          enc_arm,
    input  logic          enc_sto_valid,
    output logic [CW-1:0] out_count,
    output logic          busy,
    output logic          done
);

    localparam int FW = $clog2(FLUSH_CYCLES);
    localparam logic [FW-1:0] FLAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [FW-1:0] FONE  = FW'(1);
    localparam logic [CW-1:0] ONE   = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_RUN,
        S_FLUSH,
        S_DONE
    } state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] limit_q, limit_d;
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
    logic          rle_lat_q, rle_lat_d;
    logic          trig_pend_q, trig_pend_d;
    logic          enc_enable_q, enc_arm_q, busy_q, done_q;
    logic          gate_d;

    // Samples pass straight through while armed or running.
    assign enc_valid  = smp_valid & ((state_q == S_ARMED) | (state_q == S_RUN));
    assign enc_enable = enc_enable_q;
    assign enc_arm    = enc_arm_q;
    assign busy       = busy_q;
    assign done       = done_q;

    assign gate_d = (state_d == S_ARMED) | (state_d == S_RUN);

    // Next-state and counter update; abort overrides every transition.
    always_comb begin
        state_d      = state_q;
        limit_d      = limit_q;
        sample_cnt_d = sample_cnt_q;
        flush_cnt_d  = flush_cnt_q;
        rle_lat_d    = rle_lat_q;
        trig_pend_d  = trig_pend_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (arm) begin
                    state_d      = S_ARMED;
                    limit_d      = post_count;
                    sample_cnt_d = '0;
                    flush_cnt_d  = '0;
                    rle_lat_d    = rle_on;
                    trig_pend_d  = 1'b0;
                end
            end
            S_ARMED: begin
                if (smp_valid && (trigger || trig_pend_q)) begin
                    trig_pend_d  = 1'b0;
                    sample_cnt_d = '0;
                    state_d      = (limit_q == '0) ? S_FLUSH : S_RUN;
                end else if (trigger) begin
                    trig_pend_d = 1'b1;
                end
            end
            S_RUN: begin
                if (smp_valid) begin
                    sample_cnt_d = sample_cnt_q + ONE;
                    if (sample_cnt_q == limit_q - ONE) begin
                        state_d = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (flush_cnt_q == FLAST) begin
                    state_d = S_DONE;
                end else begin
                    flush_cnt_d = flush_cnt_q + FONE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d      = S_IDLE;
            limit_d      = limit_q;
            sample_cnt_d = sample_cnt_q;
            flush_cnt_d  = '0;
            rle_lat_d    = rle_lat_q;
            trig_pend_d  = trig_pend_q;
        end
    end

    // State, counters and registered state-decoded outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= S_IDLE;
            limit_q      <= '0;
            sample_cnt_q <= '0;
            flush_cnt_q  <= '0;
            rle_lat_q    <= 1'b0;
            trig_pend_q  <= 1'b0;
            enc_enable_q <= 1'b0;
            enc_arm_q    <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            limit_q      <= limit_d;
            sample_cnt_q <= sample_cnt_d;
            flush_cnt_q  <= flush_cnt_d;
            rle_lat_q    <= rle_lat_d;
            trig_pend_q  <= trig_pend_d;
            enc_enable_q <= gate_d & rle_lat_d;
            enc_arm_q    <= gate_d;
            busy_q       <= gate_d | (state_d == S_FLUSH);
            done_q       <= (state_d == S_DONE);
        end
    end

`ifdef RLE_CAPTURE_CTRL_OUTCNT_EN
    logic [CW-1:0] out_count_q, out_count_d;
    logic          counting;

    assign counting  = (state_q == S_ARMED) | (state_q == S_RUN) |
                       (state_q == S_FLUSH);
    assign out_count = out_count_q;

    // Output word count: cleared on accepted arm, saturating, held on abort.
    always_comb begin
        out_count_d = out_count_q;
        if (!abort) begin
            if (arm && ((state_q == S_IDLE) || (state_q == S_DONE))) begin
                out_count_d = '0;
            end else if (counting && enc_sto_valid && (out_count_q != '1)) begin
                out_count_d = out_count_q + ONE;
            end
        end
    end

    // Output word count register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_count_q <= '0;
        end else begin
            out_count_q <= out_count_d;
        end
    end
`else
    logic unused_sto;

    assign unused_sto = enc_sto_valid;
    assign out_count  = '0;
`endif

endmodule

// File: tb/tb_rle_capture_ctrl.sv
// tb_rle_capture_ctrl: directed checks of capture, flush, abort and reset.
// Output counter expectations follow RLE_CAPTURE_CTRL_OUTCNT_EN.
module tb_rle_capture_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arm, abort, rle_on, trigger, smp_valid, enc_sto_valid;
    logic [31:0] post_count;
    logic        enc_valid, enc_enable, enc_arm, busy, done;
    logic [31:0] out_count;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc, nv, nf, done_at;

    always #5 clk = ~clk;

    rle_capture_ctrl #(.CW(32), .FLUSH_CYCLES(4)) dut (
        .clk          (clk),
        .rst          (rst_n),
        .arm          (arm),
        .abort        (abort),
        .rle_on       (rle_on),
        .post_count   (post_count),
        .trigger      (trigger),
        .smp_valid    (smp_valid),
        .enc_valid    (enc_valid),
        .enc_enable   (enc_enable),
        .enc_arm      (enc_arm),
        .enc_sto_valid(enc_sto_valid),
        .out_count    (out_count),
        .busy         (busy),
        .done         (done)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr();
        cyc     = 0;
        nv      = 0;
        nf      = 0;
        done_at = -1;
    endtask

    task automatic tick();
        #1;
        if (enc_valid) nv++;
        if (busy && !enc_enable) nf++;
        if (done && done_at < 0 && cyc > 0) done_at = cyc;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        rst_n         = 1'b0;
        arm           = 1'b0;
        abort         = 1'b0;
        rle_on        = 1'b0;
        trigger       = 1'b0;
        smp_valid     = 1'b1;
        enc_sto_valid = 1'b0;
        post_count    = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_enc_valid", enc_valid, 0);
        check("rst_enc_enable", enc_enable, 0);
        check("rst_enc_arm", enc_arm, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_out_count", out_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // basic capture: 3 pre-trigger, trigger, 5 post samples
        clr();
        rle_on     = 1'b1;
        post_count = 32'd5;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check("t1_enc_arm", enc_arm, 1);
        check("t1_enc_enable", enc_enable, 1);
        check("t1_busy", busy, 1);
        repeat (3) tick();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (15) tick();
        check("t1_valid_cnt", nv, 9);
        check("t1_flush_cnt", nf, 4);
        check("t1_done_at", done_at, 14);
        check("t1_done", done, 1);
        check("t1_busy_end", busy, 0);
        check("t1_enc_valid_done", enc_valid, 0);
        check("t1_enc_arm_done", enc_arm, 0);

        // post_count 0: only the trigger sample passes
        clr();
        post_count = 32'd0;
        arm        = 1'b1;
        tick();
        arm     = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        check("t2_flush_en", enc_enable, 0);
        check("t2_flush_busy", busy, 1);
        repeat (8) tick();
        check("t2_valid_cnt", nv, 1);
        check("t2_flush_cnt", nf, 4);
        check("t2_done_at", done_at, 6);

        // sparse strobes, trigger on an empty cycle
        clr();
        post_count = 32'd2;
        for (int i = 0; i < 20; i++) begin
            arm       = (i == 0);
            smp_valid = (i % 3 == 1);
            trigger   = (i == 2);
            tick();
        end
        arm       = 1'b0;
        trigger   = 1'b0;
        smp_valid = 1'b1;
        check("t3_valid_cnt", nv, 4);
        check("t3_flush_cnt", nf, 4);
        check("t3_done_at", done_at, 15);

        // abort in RUN, compression off
        rle_on     = 1'b0;
        post_count = 32'd10;
        arm        = 1'b1;
        tick();
        arm = 1'b0;
        check("t4_enable_off", enc_enable, 0);
        check("t4_arm_on", enc_arm, 1);
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_run_abort_busy", busy, 0);
        check("t4_run_abort_done", done, 0);
        check("t4_run_abort_arm", enc_arm, 0);
        check("t4_run_abort_en", enc_enable, 0);
        check("t4_run_abort_valid", enc_valid, 0);
        clr();
        repeat (8) tick();
        check("t4_run_no_flush", nf, 0);
        check("t4_run_no_done", done_at, -1);

        // abort in FLUSH
        rle_on     = 1'b1;
        post_count = 32'd1;
        arm        = 1'b1;
        tick();
        arm     = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("t4_in_flush_en", enc_enable, 0);
        check("t4_in_flush_busy", busy, 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_fl_abort_busy", busy, 0);
        check("t4_fl_abort_done", done, 0);
        clr();
        repeat (8) tick();
        check("t4_fl_no_flush", nf, 0);
        check("t4_fl_no_done", done_at, -1);

        // abort beats arm
        arm   = 1'b1;
        abort = 1'b1;
        tick();
        arm   = 1'b0;
        abort = 1'b0;
        check("t4_arm_abort_busy", busy, 0);
        check("t4_arm_abort_arm", enc_arm, 0);

        // output word counting across RUN and FLUSH
        clr();
        post_count = 32'd5;
        for (int i = 0; i < 15; i++) begin
            arm           = (i == 0);
            trigger       = (i == 1);
            enc_sto_valid = (i inside {3, 4, 5, 6, 7, 8, 10, 12, 13});
            tick();
        end
        arm           = 1'b0;
        trigger       = 1'b0;
        enc_sto_valid = 1'b0;
        check("t5_done_at", done_at, 11);
        check("t5_done", done, 1);
`ifdef RLE_CAPTURE_CTRL_OUTCNT_EN
        check("t5_out_count", out_count, 7);
`else
        check("t5_out_count", out_count, 0);
`endif
        arm = 1'b1;
        tick();
        arm = 1'b0;
        check("t5_rearm_count", out_count, 0);
        check("t5_rearm_arm", enc_arm, 1);

        // asynchronous reset mid-RUN
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        check("t6_pre_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("t6_rst_valid", enc_valid, 0);
        check("t6_rst_arm", enc_arm, 0);
        check("t6_rst_enable", enc_enable, 0);
        check("t6_rst_busy", busy, 0);
        check("t6_rst_done", done, 0);
        check("t6_rst_out_count", out_count, 0);
        #1;
        rst_n = 1'b1;
        clr();
        post_count = 32'd2;
        arm        = 1'b1;
        tick();
        arm     = 1'b0;
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        repeat (10) tick();
        check("t6_valid_cnt", nv, 3);
        check("t6_flush_cnt", nf, 4);
        check("t6_done_at", done_at, 8);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/rle_capture_ctrl.md
# rle_capture_ctrl

Capture sequencer that sits between the sampler and `rle_enc` in the logic-analyzer datapath. It arms the encoder, gates the sample strobe from arm until the post-trigger sample count is reached, then drops the encoder `enable` for a fixed flush window so the pending run count is emitted, and finally reports completion. Without it the last run of a capture is lost.

## Interface
- `CW`, 32, width of the post-trigger and output-word counters
- `FLUSH_CYCLES`, 4, cycles `enc_enable` is held low in FLUSH (≥2)
- `clk` in 1: system clock, all logic on rising edge
- `rst` in 1: asynchronous, active-low reset
- `arm` in 1: start-capture pulse, honoured only in IDLE or DONE
- `abort` in 1: level; forces IDLE from any state
- `rle_on` in 1: configuration, RLE compression requested for this capture
- `post_count` in CW: samples to pass after the trigger sample; sampled on accepted `arm`
- `trigger` in 1: trigger-unit pulse
- `smp_valid` in 1: sample strobe from the sampler
- `enc_valid` out 1: gated sample strobe to `rle_enc.sti_valid`
- `enc_enable` out 1: to `rle_enc.enable`
- `enc_arm` out 1: to `rle_enc.arm`
- `enc_sto_valid` in 1: `rle_enc.sto_valid`, counted
- `out_count` out CW: encoder output words in current capture
- `busy` out 1: state not IDLE/DONE
- `done` out 1: state DONE

## Operation
- States: IDLE, ARMED, RUN, FLUSH, DONE (registered, one-hot or binary).
- IDLE/DONE + `arm` → ARMED; latch `post_count` into `limit`, clear `sample_cnt`, `flush_cnt`, `out_count`; latch `rle_on` into `rle_lat`.
- ARMED: `enc_valid = smp_valid`. `trigger & smp_valid` → RUN with `sample_cnt=0`; if `limit==0` go directly to FLUSH instead. `trigger` without `smp_valid` is remembered (`trig_pend`) and takes effect on the next `smp_valid`.
- RUN: `enc_valid = smp_valid`; each `smp_valid` increments `sample_cnt`; on the cycle `smp_valid` and `sample_cnt+1==limit` → FLUSH (that sample is passed). Further `trigger` ignored.
- FLUSH: `enc_valid=0`, `enc_enable=0`; `flush_cnt` counts 0..FLUSH_CYCLES-1, then → DONE.
- DONE: outputs hold; `out_count` frozen; `arm` restarts.
- `enc_enable = rle_lat` in ARMED and RUN, 0 elsewhere. If `rle_lat=0`, FLUSH still runs (encoder passes through; flush is harmless).
- `enc_arm = 1` in ARMED and RUN, 0 elsewhere.
- `out_count` increments on `enc_sto_valid` in ARMED, RUN, FLUSH; saturates at all-ones.
- `abort` has priority over every transition including `arm` in the same cycle: → IDLE, counters untouched except `flush_cnt` cleared; no flush performed.
- `sample_cnt` is CW bits; `limit` up to 2^CW−1 reachable without wrap.

## Timing
- Reset values: state IDLE, `enc_valid=0`, `enc_enable=0`, `enc_arm=0`, `out_count=0`, `busy=0`, `done=0`, all counters 0.
- `enc_valid` is combinational from registered state and `smp_valid` (zero latency, aligned with sampler data).
- `enc_enable`, `enc_arm`, `busy`, `done` are decoded from the state register: change the cycle after the causing edge.
- `arm` → `enc_arm` high 1 cycle later. Final RUN sample → `enc_enable` low next cycle for exactly FLUSH_CYCLES cycles → `done` high the following cycle.
- Reset asserted mid-capture: all outputs to reset values immediately (asynchronous), no flush.

## Configuration
- `RLE_CAPTURE_CTRL_OUTCNT_EN`: defined → `out_count` counter built as above. Undefined → counter omitted, `out_count` tied to 0, `enc_sto_valid` unused; all other behaviour identical.

## Test plan
- Reset, `rle_on=1`, arm with `post_count=5`, continuous `smp_valid`, trigger 3 cycles after arm → `enc_valid` high for 3 pre-trigger + trigger + 5 samples = 9 cycles, then `enc_enable` low 4 cycles, `done=1`.
- `post_count=0`, trigger with `smp_valid` → exactly one post-arm trigger sample passed, FLUSH next cycle, `done` after 4 cycles.
- `smp_valid` every 3rd cycle, trigger arriving on a cycle with `smp_valid=0`, `post_count=2` → RUN entered on next strobe, 2 more strobes passed, FLUSH.
- `abort` in RUN and in FLUSH, plus `abort`+`arm` same cycle → IDLE next cycle, `enc_enable=0`, `done=0`, no flush window.
- With macro defined, drive 7 `enc_sto_valid` pulses across RUN/FLUSH → `out_count=7` in DONE; re-arm → 0; without macro → `out_count` stays 0.
- Assert `rst` low mid-RUN for 1 ns off-edge → outputs at reset values immediately; `arm` after release starts clean capture.
